// File: rtl/ps2_scancode_ctrl_if.sv
// rtl/ps2_scancode_ctrl_if.sv - Wishbone classic slave bus bundle for the scan-code controller
interface ps2_scancode_ctrl_if;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [1:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic        wb_ack_o;
  logic [31:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_ack_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_ack_o, wb_dat_o
  );
endinterface

// File: rtl/ps2_scancode_ctrl.sv
// rtl/ps2_scancode_ctrl.sv - PS/2 prefix decoder, event FIFO and Wishbone register slave
module ps2_scancode_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int PREFIX_TIMEOUT = 100000
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                rx_valid_i,
  input  logic [7:0]          rx_data_i,
  input  logic                rx_err_i,
  ps2_scancode_ctrl_if.slave  wb,
  output logic                irq_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(PREFIX_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(PREFIX_TIMEOUT - 1);
  localparam logic [5:0]    FULL_CNT = 6'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state;
  logic [TW-1:0]   tmo_cnt;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [5:0]      count;
  logic            ovf, err, tmo, en, irq_en;

  logic            acc, is_rd, is_wr, pop, full;
  logic            byte_in, byte_ok, is_prefix, push, do_push;
  logic            ovf_set, err_set, tmo_set;
  logic [31:0]     rd_data;
  logic [9:0]      head;

  // Byte lanes and unused write bits are intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{wb.wb_sel_i, wb.wb_dat_i[31:11], wb.wb_dat_i[7:2]};

  assign head = mem[rd_ptr];

  // Bus decode, push/pop qualification and flag-set strobes
  always_comb begin
    acc       = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o;
    is_rd     = acc & ~wb.wb_we_i;
    is_wr     = acc & wb.wb_we_i;
    full      = (count == FULL_CNT);
    pop       = is_rd & (wb.wb_adr_i == 2'd0) & (count != 6'd0);
    byte_in   = en & rx_valid_i;
    byte_ok   = byte_in & ~rx_err_i;
    is_prefix = (rx_data_i == 8'hE0) | (rx_data_i == 8'hF0);
    push      = byte_ok & ~is_prefix;
    do_push   = push & (~full | pop);
    ovf_set   = push & full & ~pop;
    err_set   = byte_in & rx_err_i;
    tmo_set   = ~byte_in & en & (state != IDLE) & (tmo_cnt == TMO_LAST);
    rd_data   = 32'd0;
    case (wb.wb_adr_i)
      2'd0: rd_data = (count != 6'd0) ? {1'b1, 21'd0, head} : 32'd0;
      2'd1: rd_data = {21'd0, tmo, err, ovf, 2'd0, count};
      2'd2: rd_data = {30'd0, irq_en, en};
      default: rd_data = 32'd0;
    endcase
  end

  // Prefix decoder FSM with abandonment timer
  always_ff @(posedge clk_i) begin
    if (rst_i || !en) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else if (byte_in) begin
      tmo_cnt <= '0;
      if (rx_err_i) begin
        state <= IDLE;
      end else if (rx_data_i == 8'hE0) begin
        if (state == IDLE) state <= EXT;
      end else if (rx_data_i == 8'hF0) begin
        if (state == IDLE)     state <= BRK;
        else if (state == EXT) state <= EXT_BRK;
      end else begin
        state <= IDLE;
      end
    end else if (state != IDLE) begin
      if (tmo_cnt == TMO_LAST) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Event storage; entries hold {ext, rel, code}
  always_ff @(posedge clk_i) begin
    if (do_push)
      mem[wr_ptr] <= {(state == EXT) | (state == EXT_BRK),
                      (state == BRK) | (state == EXT_BRK), rx_data_i};
  end

  // FIFO pointers, sticky flags, control register, bus ack/data and irq
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      ovf         <= 1'b0;
      err         <= 1'b0;
      tmo         <= 1'b0;
      en          <= 1'b1;
      irq_en      <= 1'b0;
      wb.wb_ack_o <= 1'b0;
      wb.wb_dat_o <= 32'd0;
      irq_o       <= 1'b0;
    end else begin
      wb.wb_ack_o <= acc;
      if (acc) wb.wb_dat_o <= is_rd ? rd_data : 32'd0;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 6'd1;
      else if (pop && !do_push) count <= count - 6'd1;
      if (is_wr && wb.wb_adr_i == 2'd1) begin
        ovf <= (ovf & ~wb.wb_dat_i[8])  | ovf_set;
        err <= (err & ~wb.wb_dat_i[9])  | err_set;
        tmo <= (tmo & ~wb.wb_dat_i[10]) | tmo_set;
      end else begin
        ovf <= ovf | ovf_set;
        err <= err | err_set;
        tmo <= tmo | tmo_set;
      end
      if (is_wr && wb.wb_adr_i == 2'd2) begin
        en     <= wb.wb_dat_i[0];
        irq_en <= wb.wb_dat_i[1];
      end
      irq_o <= irq_en & (count != 6'd0);
    end
  end
endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// tb/tb_ps2_scancode_ctrl.sv - randomized self-checking bench for ps2_scancode_ctrl
`timescale 1ns/1ps
module tb_ps2_scancode_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_err = 1'b0;
  logic       irq;

  ps2_scancode_ctrl_if wb();

  ps2_scancode_ctrl #(.FIFO_DEPTH(8), .PREFIX_TIMEOUT(16)) dut (
    .clk_i(clk), .rst_i(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
    .rx_err_i(rx_err), .wb(wb.slave), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: prefix memory as two flags, event queue, sticky flags
  logic [31:0] q[$];
  bit ext_p, rel_p, m_ovf, m_err, m_tmo;

  function automatic void model_clear();
    ext_p = 0; rel_p = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit e);
    if (e) begin
      m_err = 1; model_clear();
    end else if (b == 8'hE0) begin
      if (!rel_p) ext_p = 1;
    end else if (b == 8'hF0) begin
      rel_p = 1;
    end else begin
      if (q.size() == 8) m_ovf = 1;
      else q.push_back({1'b1, 21'd0, ext_p, rel_p, b});
      model_clear();
    end
  endfunction

  function automatic void model_gap(input int g);
    if (g >= 25 && (ext_p || rel_p)) begin
      m_tmo = 1; model_clear();
    end
  endfunction

  task automatic wb_xfer(input bit we, input logic [1:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
    int n;
    bit got;
    @(negedge clk);
    wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = we;
    wb.wb_adr_i = adr; wb.wb_dat_i = wd; wb.wb_sel_i = 4'hF;
    n = 0; got = 0;
    while (n < 10 && !got) begin
      @(negedge clk); n++;
      if (wb.wb_ack_o === 1'b1) got = 1;
    end
    rd = wb.wb_dat_o;
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL wb_ack_timeout adr=%0d got no ack within 10 cycles", adr);
    end
  endtask

  task automatic wb_read(input logic [1:0] adr, output logic [31:0] rd);
    wb_xfer(1'b0, adr, 32'd0, rd);
  endtask

  task automatic wb_write(input logic [1:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wd, dummy);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit e);
    @(negedge clk);
    rx_valid = 1; rx_data = b; rx_err = e;
    @(negedge clk);
    rx_valid = 0; rx_err = 0;
  endtask

  task automatic drain(input string name);
    logic [31:0] d, exp;
    while (q.size() > 0) begin
      exp = q.pop_front();
      wb_read(2'd0, d);
      checks++;
      if (d !== exp) begin
        failures++;
        $display("FAIL %s_data got=%h exp=%h", name, d, exp);
      end
    end
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'd0) begin
      failures++;
      $display("FAIL %s_empty got=%h exp=00000000", name, d);
    end
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] d;
    wb_read(2'd1, d);
    checks++;
    if (d !== exp) begin
      failures++;
      $display("FAIL %s_status got=%h exp=%h", name, d, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0; wb.wb_we_i = 0;
    wb.wb_adr_i = 0; wb.wb_dat_i = 0; wb.wb_sel_i = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    checks++;
    if (wb.wb_ack_o !== 1'b0 || wb.wb_dat_o !== 32'd0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got ack=%b dat=%h irq=%b exp 0/0/0", wb.wb_ack_o, wb.wb_dat_o, irq);
    end
    check_status("reset", 32'h0);
    wb_read(2'd2, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL reset_ctrl got=%h exp=00000001", d); end
    drain("reset");
  endtask

  task automatic test_make_break();
    logic [31:0] d;
    wb_write(2'd2, 32'h3);
    send_byte(8'h1C, 0); model_byte(8'h1C, 0);
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL mb_irq_rise got=%b exp=1", irq); end
    send_byte(8'hF0, 0); model_byte(8'hF0, 0);
    send_byte(8'h1C, 0); model_byte(8'h1C, 0);
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h8000001C) begin failures++; $display("FAIL mb_make got=%h exp=8000001c", d); end
    void'(q.pop_front());
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL mb_irq_hold got=%b exp=1", irq); end
    wb_read(2'd0, d);
    checks++;
    if (d !== 32'h8000011C) begin failures++; $display("FAIL mb_break got=%h exp=8000011c", d); end
    void'(q.pop_front());
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL mb_irq_fall got=%b exp=0", irq); end
    drain("mb");
    wb_write(2'd2, 32'h1);
  endtask

  task automatic test_extended();
    send_byte(8'hE0, 0); model_byte(8'hE0, 0);
    send_byte(8'h75, 0); model_byte(8'h75, 0);
    send_byte(8'hE0, 0); model_byte(8'hE0, 0);
    send_byte(8'hF0, 0); model_byte(8'hF0, 0);
    send_byte(8'h75, 0); model_byte(8'h75, 0);
    checks++;
    if (q.size() != 2 || q[0] !== 32'h80000275 || q[1] !== 32'h80000375) begin
      failures++; $display("FAIL ext_model_sanity size=%0d", q.size());
    end
    drain("ext");
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      send_byte(8'(i), 0); model_byte(8'(i), 0);
    end
    check_status("ovf", 32'h108);
    drain("ovf");
    wb_write(2'd1, 32'h100); m_ovf = 0;
    check_status("ovf_clr", 32'h0);
  endtask

  task automatic test_collision();
    logic [7:0] b;
    logic [31:0] exp;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(1, 8'hDF));
      send_byte(b, 0); model_byte(b, 0);
    end
    b = 8'h5A;
    @(negedge clk);
    wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 0; wb.wb_adr_i = 2'd0;
    rx_valid = 1; rx_data = b; rx_err = 0;
    @(negedge clk);
    rx_valid = 0;
    exp = q.pop_front();
    q.push_back({1'b1, 21'd0, 2'b00, b});
    checks++;
    if (wb.wb_ack_o !== 1'b1 || wb.wb_dat_o !== exp) begin
      failures++;
      $display("FAIL coll_read got ack=%b dat=%h exp ack=1 dat=%h", wb.wb_ack_o, wb.wb_dat_o, exp);
    end
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0;
    check_status("coll", 32'h008);
    drain("coll");
  endtask

  task automatic test_timeout_error();
    send_byte(8'hE0, 0); model_byte(8'hE0, 0);
    repeat (20) @(negedge clk); model_gap(20 + 25);
    send_byte(8'h1C, 0); model_byte(8'h1C, 0);
    check_status("tmo", 32'h401);
    drain("tmo");
    wb_write(2'd1, 32'h700); m_tmo = 0;
    send_byte(8'hE0, 0); model_byte(8'hE0, 0);
    repeat (5) @(negedge clk);
    send_byte(8'h75, 0); model_byte(8'h75, 0);
    check_status("short_gap", 32'h001);
    drain("short_gap");
    send_byte(8'hF0, 1); model_byte(8'hF0, 1);
    send_byte(8'h1C, 0); model_byte(8'h1C, 0);
    check_status("err", 32'h201);
    drain("err");
    wb_write(2'd1, 32'h700); m_err = 0;
    check_status("err_clr", 32'h0);
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit e;
    int r, g;
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)      b = 8'hE0;
      else if (r < 4) b = 8'hF0;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hE0 || b == 8'hF0) b = 8'h1C;
      end
      e = ($urandom_range(0, 15) == 0);
      g = ($urandom_range(0, 7) == 0) ? $urandom_range(25, 30) : $urandom_range(0, 3);
      send_byte(b, e); model_byte(b, e);
      repeat (g) @(negedge clk);
      model_gap(g);
      if (q.size() >= 5 && !ext_p && !rel_p) drain("rand");
    end
    repeat (30) @(negedge clk); model_gap(30);
    check_status("rand", {21'd0, m_tmo, m_err, m_ovf, 2'd0, 6'(q.size())});
    drain("rand_end");
    wb_write(2'd1, 32'h700); m_tmo = 0; m_err = 0;
  endtask

  task automatic test_back_to_back();
    int acks, consec;
    bit prev;
    acks = 0; consec = 0; prev = 0;
    @(negedge clk);
    wb.wb_cyc_i = 1; wb.wb_stb_i = 1; wb.wb_we_i = 0; wb.wb_adr_i = 2'd3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (wb.wb_ack_o === 1'b1) begin
        acks++;
        if (prev) consec++;
        if (wb.wb_dat_o !== 32'd0) consec++;
      end
      prev = (wb.wb_ack_o === 1'b1);
    end
    wb.wb_cyc_i = 0; wb.wb_stb_i = 0;
    checks++;
    if (acks != 3 || consec != 0) begin
      failures++;
      $display("FAIL b2b_acks got acks=%0d bad=%0d exp acks=3 bad=0", acks, consec);
    end
  endtask

  task automatic test_disable_reset();
    logic [31:0] d;
    wb_write(2'd2, 32'h0);
    send_byte(8'h1C, 0);
    check_status("dis", 32'h0);
    wb_write(2'd2, 32'h3);
    send_byte(8'h1C, 0);
    send_byte(8'h2C, 0);
    @(negedge clk);
    check_status("pend", 32'h002);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL pend_irq got=%b exp=1", irq); end
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    checks++;
    if (irq !== 1'b0 || wb.wb_ack_o !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got irq=%b ack=%b exp 0/0", irq, wb.wb_ack_o);
    end
    check_status("rst", 32'h0);
    wb_read(2'd2, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL rst_ctrl got=%h exp=00000001", d); end
  endtask

  initial begin
    model_clear(); m_ovf = 0; m_err = 0; m_tmo = 0;
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_collision();
    test_timeout_error();
    test_random();
    test_back_to_back();
    test_disable_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
